// File: rtl/xor_share_arbiter.sv
// -----------------------------------------------------------------------------
// xor_share_arbiter
//
// Shares one external combinational XOR unit between NUM_REQ requesters.
// Requests are picked round-robin, each one goes through a three-phase
// sequence (accept, issue, respond), and the result is returned on one
// response channel tagged with the owning requester index.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   req_valid/ready per-requester handshake; at most one ready bit is set
//   req_a/req_b     packed operands, requester i at [i*WIDTH +: WIDTH]
//   xor_a/xor_b     registered operands to the shared XOR unit
//   xor_y           result from the shared XOR unit, sampled in ISSUE
//   rsp_*           response channel (valid/ready, requester id, data)
//   busy            high whenever the sequencer is not idle
//   op_count        completed responses, wraps at 16 bits
// -----------------------------------------------------------------------------
module xor_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         xor_a,
  output logic [WIDTH-1:0]         xor_b,
  input  logic [WIDTH-1:0]         xor_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy,
  output logic [15:0]              op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             busy_q, busy_d;

  logic             win_found_s;
  logic [IDW-1:0]   win_id_s;
  logic [IDW-1:0]   cand_s;
  logic             hit_s;
  logic             sel_s;
  logic [WIDTH-1:0] win_a_s;
  logic [WIDTH-1:0] win_b_s;

  // Index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return IDW'(sum);
  endfunction

  // Round-robin scan: first valid requester starting at rr_ptr.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = wrap_add(rr_ptr_q, k);
      hit_s       = !win_found_s && req_valid[cand_s];
      win_id_s    = hit_s ? cand_s : win_id_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // Operand mux selecting the winner's slices.
  always_comb begin
    win_a_s = '0;
    win_b_s = '0;
    sel_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_s   = (win_id_s == IDW'(i));
      win_a_s = sel_s ? req_a[i*WIDTH +: WIDTH] : win_a_s;
      win_b_s = sel_s ? req_b[i*WIDTH +: WIDTH] : win_b_s;
    end
  end

  // Next-state logic and the combinational accept strobe.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    op_count_d  = op_count_q;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        // Ready is suppressed while reset is held so no handshake can
        // appear to complete against a sequencer that is being cleared.
        if (win_found_s && !rst) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (win_id_s == IDW'(i));
          end
          opa_d    = win_a_s;
          opb_d    = win_b_s;
          gnt_id_d = win_id_s;
          state_d  = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        rsp_data_d  = xor_y;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          // Pointer moves only on completion, just past the served requester.
          rr_ptr_d    = wrap_add(gnt_id_q, 1);
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      op_count_q  <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_d;
      busy_q      <= busy_d;
    end
  end

  assign xor_a     = opa_q;
  assign xor_b     = opb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for xor_share_arbiter. Requesters are driven from the main
// process; a negedge monitor predicts grants from the round-robin rule,
// queues expected responses and pops/compares them as they are delivered.
// -----------------------------------------------------------------------------
module tb_xor_share_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [W-1:0]   xor_a, xor_b, xor_y;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic [15:0]    op_count;

  xor_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .xor_a(xor_a), .xor_b(xor_b), .xor_y(xor_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count)
  );

  // The shared XOR unit itself.
  assign xor_y = xor_a ^ xor_b;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
  } exp_t;

  exp_t         sb_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [N-1:0] rv = '0;
  logic [N-1:0] acc_flag = '0;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  int           m_ptr = 0;
  logic         m_busy = 1'b0;
  int           acc_cyc = 0;
  logic [15:0]  exp_count = 16'd0;
  int           g_log[$];
  int           g_cyc[$];
  logic [IDW-1:0] last_id = '0;
  logic [W-1:0]   last_data = '0;

  logic         c_bsy;
  logic         c_v;
  logic [N-1:0] c_rdy;
  int           c_w;
  int           c_idx;
  exp_t         c_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    req_valid = rv;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  endtask

  task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    rv[i]   = 1'b1;
    drive();
  endtask

  // Advance one cycle; requesters whose handshake completed drop valid.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) begin
        rv[i]       = 1'b0;
        acc_flag[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((rv != '0 || m_busy || sb_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    if (rv != '0 || m_busy || sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", max);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model + scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      c_bsy = m_busy;
      chk("busy", busy, c_bsy);
      chk("op_count", op_count, exp_count);
      c_rdy = '0;
      c_w   = -1;
      if (!c_bsy) begin
        for (int k = 0; k < N; k++) begin
          c_idx = (m_ptr + k) % N;
          if (c_w < 0 && rv[c_idx]) c_w = c_idx;
        end
      end
      if (c_w >= 0) c_rdy[c_w] = 1'b1;
      chk("req_ready", req_ready, c_rdy);
      if (c_w >= 0) begin
        c_e.id = IDW'(c_w);
        c_e.a  = op_a[c_w];
        c_e.b  = op_b[c_w];
        sb_q.push_back(c_e);
        m_busy      = 1'b1;
        acc_cyc     = cyc;
        acc_flag[c_w] = 1'b1;
        g_log.push_back(c_w);
        g_cyc.push_back(cyc);
        chk("rsp_valid_at_accept", rsp_valid, 1'b0);
      end else begin
        c_v = c_bsy && (cyc - acc_cyc >= 2);
        chk("rsp_valid", rsp_valid, c_v);
        if (c_bsy && sb_q.size() != 0) begin
          chk("xor_a", xor_a, sb_q[0].a);
          chk("xor_b", xor_b, sb_q[0].b);
        end
        if (c_v && rsp_valid) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got id %0d data %0h, expected none", rsp_id, rsp_data);
          end else begin
            c_e = sb_q[0];
            chk("rsp_id", rsp_id, c_e.id);
            chk("rsp_data", rsp_data, c_e.a ^ c_e.b);
            if (rsp_ready) begin
              c_e       = sb_q.pop_front();
              m_busy    = 1'b0;
              m_ptr     = (int'(c_e.id) + 1) % N;
              exp_count = exp_count + 16'd1;
              last_id   = c_e.id;
              last_data = c_e.a ^ c_e.b;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    drive();
    #12;
    // Reset values while reset is held.
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_xor_a", xor_a, '0);
    chk("rst_xor_b", xor_b, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_id", rsp_id, '0);
    chk("rst_op_count", op_count, 16'd0);
    #11 rst = 1'b0;

    // Idle for 10 cycles; monitor checks ready/valid/busy/count each cycle.
    repeat (10) step();

    // All four requesters continuously valid, a=i, b=0xFF.
    rsp_ready = 1'b1;
    g_log.delete();
    g_cyc.delete();
    guard = 0;
    while (g_log.size() < 5 && guard < 60) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i]) post(i, W'(i), 8'hFF);
      end
      step();
      guard++;
    end
    wait_idle(60);
    if (g_log.size() < 5) begin
      total++;
      bad++;
      $display("FAIL rr_order: got %0d grants, expected 5", g_log.size());
    end else begin
      chk("rr_order0", g_log[0], 0);
      chk("rr_order1", g_log[1], 1);
      chk("rr_order2", g_log[2], 2);
      chk("rr_order3", g_log[3], 3);
      chk("rr_order4", g_log[4], 0);
      for (int k = 0; k < 4; k++) chk("accept_spacing", g_cyc[k+1] - g_cyc[k], 3);
    end

    // Single request on port 2.
    post(2, 8'hA5, 8'h0F);
    wait_idle(20);
    chk("single_id", last_id, 2);
    chk("single_data", last_data, 8'hAA);

    // Response backpressure for 5 cycles on data 0x3C from port 1.
    rsp_ready = 1'b0;
    post(1, 8'h69, 8'h55);
    guard = 0;
    while (!rsp_valid && guard < 10) begin
      step();
      guard++;
    end
    post(0, 8'h01, 8'h02);
    post(3, 8'h03, 8'h04);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_id", rsp_id, 1);
      chk("bp_data", rsp_data, 8'h3C);
      chk("bp_no_ready", req_ready, '0);
      step();
    end
    rsp_ready = 1'b1;
    wait_idle(30);

    // Randomized traffic with random backpressure and withdrawn requests.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 3) == 0) begin
          post(i, W'($urandom), W'($urandom));
        end else if (rv[i] && $urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0;
          drive();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    wait_idle(100);

    // Async reset while a request is in ISSUE.
    post(2, 8'h10, 8'h20);
    wait_idle(20);
    post(1, 8'h11, 8'h22);
    step();
    post(3, 8'h33, 8'h44);
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_req_ready", req_ready, '0);
    chk("arst_xor_a", xor_a, '0);
    chk("arst_xor_b", xor_b, '0);
    chk("arst_op_count", op_count, 16'd0);
    sb_q.delete();
    m_busy    = 1'b0;
    m_ptr     = 0;
    exp_count = 16'd0;
    acc_flag  = '0;
    #10 rst = 1'b0;
    g_log.delete();
    guard = 0;
    while (g_log.size() < 1 && guard < 10) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i]) post(i, W'(i), W'(8'h80 + i));
      end
      step();
      guard++;
    end
    if (g_log.size() < 1) begin
      total++;
      bad++;
      $display("FAIL post_reset_grant: no grant, expected port 0");
    end else begin
      chk("post_reset_grant", g_log[0], 0);
    end
    wait_idle(40);

    // op_count wrap from 0xFFFF.
    step();
    #1 force dut.op_count_q = 16'hFFFF;
    exp_count = 16'hFFFF;
    step();
    step();
    #1 release dut.op_count_q;
    step();
    post(0, W'($urandom), W'($urandom));
    wait_idle(20);
    chk("op_count_wrap", op_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_share_arbiter.md
Name: xor_share_arbiter

Overview:
- Shares one combinational bitwise-XOR datapath (operands a, b; result y) between NUM_REQ requesters.
- Uses round-robin arbitration and a valid/ready handshake on each request port.
- Returns each result on a single response channel, tagged with the requester index.
- Sits between requester logic and the single shared XOR unit; owns all sequencing of that unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- IDW, 2, requester-index width; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B; same packing as req_a.
- xor_a  out  WIDTH  operand A to the shared XOR datapath.
- xor_b  out  WIDTH  operand B to the shared XOR datapath.
- xor_y  in  WIDTH  result from the shared XOR datapath (combinational, settles within one cycle).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  WIDTH  XOR result.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  16  count of completed responses; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, grant id=0, operand regs=0, rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0, busy=0, req_ready=0, xor_a=xor_b=0.
  - Reset mid-operation abandons the in-flight transaction; no response is ever issued for it.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other bits 0. The handshake completes in that cycle.
  - On the clock edge: latch req_a/req_b slice of winner into operand regs, grant id <= winner, state -> ISSUE.
  - If no req_valid is set, remain in IDLE with req_ready=0.
- ISSUE:
  - xor_a/xor_b driven from operand regs (registered outputs, stable ISSUE through RESP).
  - On the edge: rsp_data <= xor_y, rsp_id <= grant id, rsp_valid <= 1, state -> RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On the edge with rsp_ready=1: rsp_valid <= 0, op_count <= op_count+1, rr_ptr <= (grant id+1) mod NUM_REQ, state -> IDLE.
- req_ready is 0 in ISSUE and RESP.
- Timing:
  - Accept in cycle N gives rsp_valid high from cycle N+2.
  - Minimum spacing between accepts is 3 cycles (accept, issue, response with rsp_ready=1).
- Requester rule: requesters hold req_valid and operands stable until req_ready. Deasserting req_valid before grant is legal and is simply not arbitrated.
- Fairness: a requester whose req_valid stays continuously high is granted within NUM_REQ grants.
- Simultaneous events: a req_valid rising during ISSUE/RESP waits for IDLE. rr_ptr updates only on response completion, never on accept.
- rsp_data width equals WIDTH; no truncation or extension.
- xor_a/xor_b retain their last operands while in IDLE.

Test Plan:
- After reset release, with all req_valid=0 -> req_ready=0, rsp_valid=0, busy=0, op_count=0 for 10 cycles.
- Single request on port 2, a=0xA5, b=0x0F, rsp_ready=1 -> req_ready=4'b0100 for exactly one cycle; rsp_valid 2 cycles later with rsp_id=2, rsp_data=0xAA; op_count=1.
- All four ports valid continuously, rsp_ready=1, port i operands a=i, b=0xFF -> grant order 0,1,2,3,0; rsp_data 0xFF, 0xFE, 0xFD, 0xFC; one accept every 3 cycles.
- Response backpressure: rsp_ready=0 for 5 cycles on a response with rsp_data=0x3C -> rsp_valid, rsp_id and rsp_data held; no req_ready asserted; completes on the first rsp_ready=1 cycle.
- Async rst pulse asserted in ISSUE (mid-clock) -> all outputs immediately at reset values; no response for the abandoned request; next grant begins at port 0.
- op_count preloaded to 0xFFFF via 65535 completions (or forced) -> the next completion gives op_count=0x0000.
